reaction_session: RTL and testbench

//  Multi-round session controller for the reaction-timer round engine. Starts a

---
 rtl/reaction_session.sv | 133 +++++++++++++
 tb/tb_reaction_session.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_session.sv
// Multi-round session controller for the reaction-timer engine.
// Runs ROUNDS attempts, classifies outcomes and accumulates statistics.
module reaction_session #(
  parameter int ROUNDS = 5,
  parameter int TICK_W = 28,
  parameter int SUM_W  = 32
) (
  input  logic              i_clk_50m,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [2:0]        i_rt_state,
  input  logic [TICK_W-1:0] i_rt_ticks,
  output logic              o_rt_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [3:0]        o_round,
  output logic [3:0]        o_valid_cnt,
  output logic [3:0]        o_early_cnt,
  output logic [3:0]        o_late_cnt,
  output logic [TICK_W-1:0] o_best,
  output logic [SUM_W-1:0]  o_sum
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_WAIT, S_DONE
  } state_t;

  localparam logic [2:0] RT_IDLE  = 3'b000;
  localparam logic [2:0] RT_LATE  = 3'b011;
  localparam logic [2:0] RT_EARLY = 3'b110;
  localparam logic [2:0] RT_VALID = 3'b100;
  localparam logic [3:0] LAST     = 4'(ROUNDS);

  state_t     state, state_nxt;
  logic [2:0] prev_rt;
  logic       is_outcome;
  logic       evt;
  logic       start_ok;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_sat;

  assign is_outcome = (i_rt_state == RT_VALID) ||
                      (i_rt_state == RT_EARLY) ||
                      (i_rt_state == RT_LATE);
  // Abort always beats a same-cycle outcome or start.
  assign evt = (state == S_RUN) && is_outcome &&
               (prev_rt != i_rt_state) && !i_abort;
  assign start_ok = (state == S_IDLE) && i_start && !i_abort;

  assign sum_ext = {1'b0, o_sum} + (SUM_W+1)'(i_rt_ticks);
  assign sum_sat = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];

  // State register and engine-state history for edge detection.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state   <= S_IDLE;
      prev_rt <= RT_IDLE;
    end else begin
      state   <= state_nxt;
      prev_rt <= i_rt_state;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    o_rt_rst  = 1'b1;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_RUN;
      end
      S_RUN: begin
        o_rt_rst = 1'b0;
        o_busy   = 1'b1;
        if (i_abort) state_nxt = S_IDLE;
        else if (evt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_rt_rst = 1'b0;
        o_busy   = 1'b1;
        if (i_abort)
          state_nxt = S_IDLE;
        else if (i_rt_state == RT_IDLE)
          state_nxt = (o_round == LAST) ? S_DONE : S_RUN;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Session statistics: cleared on accepted start, updated per event.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      o_aborted   <= 1'b0;
      o_round     <= '0;
      o_valid_cnt <= '0;
      o_early_cnt <= '0;
      o_late_cnt  <= '0;
      o_best      <= '1;
      o_sum       <= '0;
    end else if (start_ok) begin
      o_aborted   <= 1'b0;
      o_round     <= '0;
      o_valid_cnt <= '0;
      o_early_cnt <= '0;
      o_late_cnt  <= '0;
      o_best      <= '1;
      o_sum       <= '0;
    end else begin
      if (i_abort) o_aborted <= 1'b1;
      if (evt) begin
        o_round <= o_round + 4'd1;
        if (i_rt_state == RT_VALID) begin
          o_valid_cnt <= o_valid_cnt + 4'd1;
          o_sum       <= sum_sat;
          if (i_rt_ticks < o_best) o_best <= i_rt_ticks;
        end
        if (i_rt_state == RT_EARLY)
          o_early_cnt <= o_early_cnt + 4'd1;
        if (i_rt_state == RT_LATE)
          o_late_cnt <= o_late_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_reaction_session.sv
// Bench for reaction_session: vector table plus
// hand-written multi-cycle sequences.
module tb_reaction_session;

  localparam int TW = 28;
  localparam int SW = 29;
  localparam logic [TW-1:0] NB = '1;
  localparam logic [SW-1:0] SAT = '1;
  localparam logic [2:0] IDL = 3'b000;
  localparam logic [2:0] ARM = 3'b001;
  localparam logic [2:0] LAT = 3'b011;
  localparam logic [2:0] EAR = 3'b110;
  localparam logic [2:0] VAL = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [2:0]    rt;
  logic [TW-1:0] ticks;
  logic          rt_rst, busy, done, aborted;
  logic [3:0]    rnd, vc, ec, lc;
  logic [TW-1:0] best;
  logic [SW-1:0] sum;

  int n_chk = 0;
  int n_err = 0;

  reaction_session #(.ROUNDS(3), .TICK_W(TW), .SUM_W(SW)) dut (
    .i_clk_50m  (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_rt_state (rt),
    .i_rt_ticks (ticks),
    .o_rt_rst   (rt_rst),
    .o_busy     (busy),
    .o_done     (done),
    .o_aborted  (aborted),
    .o_round    (rnd),
    .o_valid_cnt(vc),
    .o_early_cnt(ec),
    .o_late_cnt (lc),
    .o_best     (best),
    .o_sum      (sum)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic          st, ab;
    logic [2:0]    rt;
    logic [TW-1:0] tk;
    logic          rr, by, dn, ad;
    logic [3:0]    rd, v, e, l;
    logic [TW-1:0] bs;
    logic [SW-1:0] sm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic st, logic ab, logic [2:0] r, int tk,
    logic rr, logic by, logic dn, logic ad,
    int rd, int v, int e, int l,
    logic [TW-1:0] bs, int sm);
    vec_t x;
    x.st = st; x.ab = ab; x.rt = r; x.tk = TW'(tk);
    x.rr = rr; x.by = by; x.dn = dn; x.ad = ad;
    x.rd = 4'(rd); x.v = 4'(v); x.e = 4'(e); x.l = 4'(l);
    x.bs = bs; x.sm = SW'(sm);
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(logic s, logic a, logic [2:0] r,
                       logic [TW-1:0] t);
    start = s; abort = a; rt = r; ticks = t;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_vec(int i, vec_t x);
    logic [31:0] ga, ex;
    ga = {rt_rst, busy, done, aborted, rnd, vc, ec, lc, 12'd0};
    ex = {x.rr, x.by, x.dn, x.ad, x.rd, x.v, x.e, x.l, 12'd0};
    n_chk++;
    if (ga !== ex || best !== x.bs || sum !== x.sm) begin
      n_err++;
      $display("FAIL row%0d: got ctl=%h best=%0d sum=%0d expected ctl=%h best=%0d sum=%0d",
               i, ga, best, sum, ex, x.bs, x.sm);
    end
    chk($sformatf("row%0d_invariant", i),
        32'(vc) + 32'(ec) + 32'(lc), 32'(rnd));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, IDL, 0);
    // session 1: three VALID rounds
    tbl.push_back(mk(1,0,IDL,0,   0,1,0,0, 0,0,0,0,NB,0));
    tbl.push_back(mk(0,0,ARM,0,   0,1,0,0, 0,0,0,0,NB,0));
    tbl.push_back(mk(0,0,VAL,300, 0,1,0,0, 1,1,0,0,300,300));
    tbl.push_back(mk(0,0,VAL,300, 0,1,0,0, 1,1,0,0,300,300));
    tbl.push_back(mk(0,0,IDL,0,   0,1,0,0, 1,1,0,0,300,300));
    tbl.push_back(mk(0,0,VAL,200, 0,1,0,0, 2,2,0,0,200,500));
    tbl.push_back(mk(0,0,IDL,0,   0,1,0,0, 2,2,0,0,200,500));
    tbl.push_back(mk(0,0,VAL,250, 0,1,0,0, 3,3,0,0,200,750));
    tbl.push_back(mk(0,0,IDL,0,   1,0,1,0, 3,3,0,0,200,750));
    tbl.push_back(mk(0,0,IDL,0,   1,0,0,0, 3,3,0,0,200,750));
    tbl.push_back(mk(0,0,VAL,5,   1,0,0,0, 3,3,0,0,200,750));
    // session 2: EARLY, undefined, LATE, VALID
    tbl.push_back(mk(1,0,IDL,0,   0,1,0,0, 0,0,0,0,NB,0));
    tbl.push_back(mk(0,0,EAR,0,   0,1,0,0, 1,0,1,0,NB,0));
    tbl.push_back(mk(0,0,IDL,0,   0,1,0,0, 1,0,1,0,NB,0));
    tbl.push_back(mk(0,0,3'b101,9,0,1,0,0, 1,0,1,0,NB,0));
    tbl.push_back(mk(0,0,LAT,0,   0,1,0,0, 2,0,1,1,NB,0));
    tbl.push_back(mk(0,0,IDL,0,   0,1,0,0, 2,0,1,1,NB,0));
    tbl.push_back(mk(0,0,VAL,100, 0,1,0,0, 3,1,1,1,100,100));
    tbl.push_back(mk(1,0,VAL,100, 0,1,0,0, 3,1,1,1,100,100));
    tbl.push_back(mk(0,0,IDL,0,   1,0,1,0, 3,1,1,1,100,100));
    tbl.push_back(mk(0,0,IDL,0,   1,0,0,0, 3,1,1,1,100,100));
    // session 3: abort after round 1, then restart
    tbl.push_back(mk(1,0,IDL,0,   0,1,0,0, 0,0,0,0,NB,0));
    tbl.push_back(mk(0,0,VAL,400, 0,1,0,0, 1,1,0,0,400,400));
    tbl.push_back(mk(0,0,IDL,0,   0,1,0,0, 1,1,0,0,400,400));
    tbl.push_back(mk(0,1,EAR,0,   1,0,0,1, 1,1,0,0,400,400));
    tbl.push_back(mk(0,0,IDL,0,   1,0,0,1, 1,1,0,0,400,400));
    tbl.push_back(mk(1,1,IDL,0,   1,0,0,1, 1,1,0,0,400,400));
    tbl.push_back(mk(1,0,IDL,0,   0,1,0,0, 0,0,0,0,NB,0));
    tbl.push_back(mk(1,0,ARM,0,   0,1,0,0, 0,0,0,0,NB,0));
    tbl.push_back(mk(0,0,LAT,0,   0,1,0,0, 1,0,0,1,NB,0));
    tbl.push_back(mk(0,0,IDL,0,   0,1,0,0, 1,0,0,1,NB,0));
    tbl.push_back(mk(0,1,IDL,0,   1,0,0,1, 1,0,0,1,NB,0));

    step(); step();
    rst = 1'b0;
    step();
    chk("rst_rt_rst", 32'(rt_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_best", 32'(best), 32'h0FFFFFFF);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_counts", {16'd0, rnd, vc, ec, lc}, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].ab, tbl[i].rt, tbl[i].tk);
      step();
      chk_vec(i, tbl[i]);
    end

    // VALID held for a long time counts once
    drive(1, 0, IDL, 0); step();
    drive(0, 0, ARM, 0); step();
    drive(0, 0, VAL, 123);
    for (int k = 0; k < 200; k++) begin
      step();
      if (rnd !== 4'd1 || vc !== 4'd1) begin
        chk("hold_once", {24'd0, rnd, vc}, 32'h11);
        break;
      end
    end
    chk("hold_round", 32'(rnd), 1);
    chk("hold_valid", 32'(vc), 1);
    chk("hold_busy", 32'(busy), 1);
    drive(0, 0, IDL, 0); step();
    chk("hold_back_run", {30'd0, busy, rt_rst}, 32'h2);
    chk("hold_round_after", 32'(rnd), 1);
    drive(0, 1, IDL, 0); step();
    drive(0, 0, IDL, 0);

    // saturating sum: three all-ones ticks into 29 bits
    drive(1, 0, IDL, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, VAL, NB); step();
      drive(0, 0, IDL, 0);
      if (k < 2) step();
    end
    chk("sat_sum", 32'(sum), 32'(SAT));
    chk("sat_best", 32'(best), 32'(NB));
    chk("sat_valid", 32'(vc), 3);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        step();
        if (done) seen = 1'b1;
      end
      chk("sat_done_seen", 32'(seen), 1);
    end
    step();
    chk("sat_sum_held", 32'(sum), 32'(SAT));

    // synchronous reset mid-session
    drive(1, 0, IDL, 0); step();
    drive(0, 0, VAL, 77); step();
    chk("mid_round", 32'(rnd), 1);
    drive(0, 0, IDL, 0);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mid_rst_rt_rst", 32'(rt_rst), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_round", 32'(rnd), 0);
    chk("mid_rst_best", 32'(best), 32'(NB));
    chk("mid_rst_sum", 32'(sum), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
